fsm_seq_ctrl: RTL and testbench

Multi-channel, parametrised successor to the single-channel Idle/Start/Stop/Clear sequence controller. Each of CH independent channels walks the four-state sequence on its own input A. Transitions take effect only after A has been stable for a programmable number of cycles. Each channel has a programmable dwell timeout back to Idle, registered one-cycle K1/K2 pulses and an error pulse. It sits between raw control inputs and downstream start/clear logic.

---
 rtl/fsm_seq_ctrl.sv | 152 +++++++++++++++
 tb/tb_fsm_seq_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fsm_seq_ctrl.sv
// fsm_seq_ctrl -- multi-channel Idle/Start/Stop/Clear sequence controller.
//
// Each of CH channels steps Idle -> Start -> Stop -> Clear -> Idle on its own
// input A. A step is taken only once A has held the level the current state is
// waiting for for hold+1 consecutive cycles. A channel that dwells tmo cycles in
// any non-Idle state is forced back to Idle and reports err.
//
// Ports
//   Clock          clock, all state changes on the rising edge
//   Reset          synchronous, active-low reset
//   en   [CH]      per-channel enable; low parks the channel in Idle
//   A    [CH]      per-channel sequence input
//   hold [HOLD_W]  qualification length shared by all channels
//   tmo  [TMO_W]   dwell limit for Start/Stop/Clear; 0 disables the timeout
//   state[2*CH]    channel c state at [2c+1:2c]: Idle=00 Start=01 Stop=10 Clear=11
//   K2   [CH]      one-cycle pulse on Stop->Clear
//   K1   [CH]      one-cycle pulse on Clear->Idle
//   err  [CH]      one-cycle pulse on a timeout return to Idle
//   busy           high while any channel is outside Idle
module fsm_seq_ctrl #(
    parameter int CH     = 4,
    parameter int HOLD_W = 4,
    parameter int TMO_W  = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [CH-1:0]     en,
    input  logic [CH-1:0]     A,
    input  logic [HOLD_W-1:0] hold,
    input  logic [TMO_W-1:0]  tmo,
    output logic [2*CH-1:0]   state,
    output logic [CH-1:0]     K2,
    output logic [CH-1:0]     K1,
    output logic [CH-1:0]     err,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_STOP  = 2'b10,
        ST_CLEAR = 2'b11
    } state_t;

    state_t            state_q [CH];
    state_t            state_d [CH];
    logic [HOLD_W-1:0] sc_q    [CH];
    logic [HOLD_W-1:0] sc_d    [CH];
    logic [TMO_W-1:0]  dc_q    [CH];
    logic [TMO_W-1:0]  dc_d    [CH];
    logic [CH-1:0]     k1_q, k1_d;
    logic [CH-1:0]     k2_q, k2_d;
    logic [CH-1:0]     err_q, err_d;
    logic              busy_q, busy_d;

    logic [CH-1:0]     match;
    logic [CH-1:0]     qual;
    logic [CH-1:0]     tmo_hit;

    // Saturating increments: a saturated counter stays put and therefore can
    // never re-match a smaller hold/tmo value until it is cleared.
    function automatic logic [HOLD_W-1:0] sc_inc(input logic [HOLD_W-1:0] v);
        return (&v) ? v : v + HOLD_W'(1);
    endfunction

    function automatic logic [TMO_W-1:0] dc_inc(input logic [TMO_W-1:0] v);
        return (&v) ? v : v + TMO_W'(1);
    endfunction

    always_comb begin
        match   = '0;
        qual    = '0;
        tmo_hit = '0;
        k1_d    = '0;
        k2_d    = '0;
        err_d   = '0;
        busy_d  = 1'b0;
        for (int c = 0; c < CH; c++) begin
            state_d[c] = state_q[c];
            sc_d[c]    = sc_q[c];
            dc_d[c]    = dc_q[c];

            // Idle and Stop wait for A high, Start and Clear for A low.
            match[c]   = (A[c] == ~state_q[c][0]);
            qual[c]    = match[c] && (sc_q[c] == hold);
            tmo_hit[c] = (tmo != '0) && (state_q[c] != ST_IDLE)
                         && (dc_q[c] == tmo - TMO_W'(1)) && !qual[c];

            if (!en[c]) begin
                state_d[c] = ST_IDLE;
                sc_d[c]    = '0;
                dc_d[c]    = '0;
            end else if (qual[c]) begin
                // Sequence order equals encoding order, so advance wraps Clear->Idle.
                state_d[c] = state_t'(state_q[c] + 2'd1);
                sc_d[c]    = '0;
                dc_d[c]    = '0;
                k2_d[c]    = (state_q[c] == ST_STOP);
                k1_d[c]    = (state_q[c] == ST_CLEAR);
            end else if (tmo_hit[c]) begin
                state_d[c] = ST_IDLE;
                sc_d[c]    = '0;
                dc_d[c]    = '0;
                err_d[c]   = 1'b1;
            end else begin
                sc_d[c] = match[c] ? sc_inc(sc_q[c]) : '0;
                dc_d[c] = (state_q[c] == ST_IDLE) ? '0 : dc_inc(dc_q[c]);
            end

            // Built from next state so busy lands on the same edge as state.
            busy_d = busy_d | (state_d[c] != ST_IDLE);
        end
    end

    // ---- state / counter / pulse registers ----
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            for (int c = 0; c < CH; c++) begin
                state_q[c] <= ST_IDLE;
                sc_q[c]    <= '0;
                dc_q[c]    <= '0;
            end
            k1_q   <= '0;
            k2_q   <= '0;
            err_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                state_q[c] <= state_d[c];
                sc_q[c]    <= sc_d[c];
                dc_q[c]    <= dc_d[c];
            end
            k1_q   <= k1_d;
            k2_q   <= k2_d;
            err_q  <= err_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        state = '0;
        for (int c = 0; c < CH; c++) begin
            state[2*c +: 2] = state_q[c];
        end
    end

    assign K1   = k1_q;
    assign K2   = k2_q;
    assign err  = err_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// Directed bench for fsm_seq_ctrl (CH=4, HOLD_W=4, TMO_W=8). Each step drives
// the inputs, queues the outputs expected after the next rising edge, then pops
// and checks them 1 time unit after that edge.
module tb_fsm_seq_ctrl;

    logic       Clock;
    logic       Reset;
    logic [3:0] en;
    logic [3:0] A;
    logic [3:0] hold;
    logic [7:0] tmo;
    logic [7:0] state;
    logic [3:0] K2;
    logic [3:0] K1;
    logic [3:0] err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [7:0] st;
        logic [3:0] k2;
        logic [3:0] k1;
        logic [3:0] er;
        logic       bz;
    } exp_t;

    exp_t exp_q[$];

    fsm_seq_ctrl #(.CH(4), .HOLD_W(4), .TMO_W(8)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .en    (en),
        .A     (A),
        .hold  (hold),
        .tmo   (tmo),
        .state (state),
        .K2    (K2),
        .K1    (K1),
        .err   (err),
        .busy  (busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_next();
        exp_t x;
        x = exp_q.pop_front();
        checks++;
        assert ({state, K2, K1, err, busy} === {x.st, x.k2, x.k1, x.er, x.bz})
        else begin
            errors++;
            $error("FAIL %s: got st=%b K2=%b K1=%b err=%b busy=%b, expected st=%b K2=%b K1=%b err=%b busy=%b",
                   x.tag, state, K2, K1, err, busy, x.st, x.k2, x.k1, x.er, x.bz);
        end
    endtask

    // busy is expected high exactly when some channel is outside Idle.
    task automatic step(input string tag, input logic rst_n, input logic [3:0] e,
                        input logic [3:0] a, input logic [7:0] xs,
                        input logic [3:0] xk2, input logic [3:0] xk1,
                        input logic [3:0] xer);
        exp_t x;
        Reset = rst_n;
        en    = e;
        A     = a;
        x.tag = tag;
        x.st  = xs;
        x.k2  = xk2;
        x.k1  = xk1;
        x.er  = xer;
        x.bz  = (xs != 8'h00);
        exp_q.push_back(x);
        @(posedge Clock);
        #1;
        check_next();
    endtask

    initial begin
        int         pat_a [4];
        logic [7:0] xs;
        logic [3:0] xa, xk1, xk2;
        pat_a = '{1, 0, 1, 0};

        Reset = 1'b0; en = 4'hF; A = 4'h0; hold = 4'd0; tmo = 8'd0;

        step("reset0", 1'b0, 4'hF, 4'h0, 8'h00, 4'h0, 4'h0, 4'h0);
        step("reset1", 1'b0, 4'hF, 4'hF, 8'h00, 4'h0, 4'h0, 4'h0);

        // ch0 minimum sequence, hold=0
        step("seq0_start", 1'b1, 4'hF, 4'h1, 8'h01, 4'h0, 4'h0, 4'h0);
        step("seq0_stop",  1'b1, 4'hF, 4'h0, 8'h02, 4'h0, 4'h0, 4'h0);
        step("seq0_clear", 1'b1, 4'hF, 4'h1, 8'h03, 4'h1, 4'h0, 4'h0);
        step("seq0_idle",  1'b1, 4'hF, 4'h0, 8'h00, 4'h0, 4'h1, 4'h0);
        step("seq0_quiet", 1'b1, 4'hF, 4'h0, 8'h00, 4'h0, 4'h0, 4'h0);

        // ch1 debounce, hold=3
        hold = 4'd3;
        for (int i = 0; i < 3; i++)
            step($sformatf("h3_short%0d", i), 1'b1, 4'hF, 4'h2, 8'h00, 4'h0, 4'h0, 4'h0);
        step("h3_drop", 1'b1, 4'hF, 4'h0, 8'h00, 4'h0, 4'h0, 4'h0);
        for (int i = 0; i < 3; i++)
            step($sformatf("h3_wait%0d", i), 1'b1, 4'hF, 4'h2, 8'h00, 4'h0, 4'h0, 4'h0);
        step("h3_start", 1'b1, 4'hF, 4'h2, 8'h04, 4'h0, 4'h0, 4'h0);
        step("h3_lo0",    1'b1, 4'hF, 4'h0, 8'h04, 4'h0, 4'h0, 4'h0);
        step("h3_lo1",    1'b1, 4'hF, 4'h0, 8'h04, 4'h0, 4'h0, 4'h0);
        step("h3_glitch", 1'b1, 4'hF, 4'h2, 8'h04, 4'h0, 4'h0, 4'h0);
        for (int i = 0; i < 3; i++)
            step($sformatf("h3_relo%0d", i), 1'b1, 4'hF, 4'h0, 8'h04, 4'h0, 4'h0, 4'h0);
        step("h3_stop", 1'b1, 4'hF, 4'h0, 8'h08, 4'h0, 4'h0, 4'h0);
        step("h3_en_off", 1'b1, 4'hD, 4'h0, 8'h00, 4'h0, 4'h0, 4'h0);
        hold = 4'd0;

        // ch2 dwell timeout, tmo=5
        tmo = 8'd5;
        step("tmo_enter", 1'b1, 4'hF, 4'h4, 8'h10, 4'h0, 4'h0, 4'h0);
        for (int i = 0; i < 4; i++)
            step($sformatf("tmo_dwell%0d", i), 1'b1, 4'hF, 4'h4, 8'h10, 4'h0, 4'h0, 4'h0);
        step("tmo_fire",  1'b1, 4'hF, 4'h4, 8'h00, 4'h0, 4'h0, 4'h4);
        step("tmo_after", 1'b1, 4'hF, 4'h0, 8'h00, 4'h0, 4'h0, 4'h0);

        // same dwell, but the qualified level arrives in the timeout cycle
        step("race_enter", 1'b1, 4'hF, 4'h4, 8'h10, 4'h0, 4'h0, 4'h0);
        for (int i = 0; i < 4; i++)
            step($sformatf("race_dwell%0d", i), 1'b1, 4'hF, 4'h4, 8'h10, 4'h0, 4'h0, 4'h0);
        step("race_stop",  1'b1, 4'hF, 4'h0, 8'h20, 4'h0, 4'h0, 4'h0);
        step("race_clear", 1'b1, 4'hF, 4'h4, 8'h30, 4'h4, 4'h0, 4'h0);
        step("race_idle",  1'b1, 4'hF, 4'h0, 8'h00, 4'h0, 4'h4, 4'h0);
        tmo = 8'd0;

        // ch3 disabled while in Stop with a qualifying A
        step("en3_start", 1'b1, 4'hF, 4'h8, 8'h40, 4'h0, 4'h0, 4'h0);
        step("en3_stop",  1'b1, 4'hF, 4'h0, 8'h80, 4'h0, 4'h0, 4'h0);
        step("en3_off",   1'b1, 4'h7, 4'h8, 8'h00, 4'h0, 4'h0, 4'h0);
        step("en3_back",  1'b1, 4'hF, 4'h0, 8'h00, 4'h0, 4'h0, 4'h0);

        // reset with every channel in Clear
        step("all_start", 1'b1, 4'hF, 4'hF, 8'h55, 4'h0, 4'h0, 4'h0);
        step("all_stop",  1'b1, 4'hF, 4'h0, 8'hAA, 4'h0, 4'h0, 4'h0);
        step("all_clear", 1'b1, 4'hF, 4'hF, 8'hFF, 4'hF, 4'h0, 4'h0);
        step("all_reset", 1'b0, 4'hF, 4'h0, 8'h00, 4'h0, 4'h0, 4'h0);
        step("all_rel",   1'b1, 4'hF, 4'h0, 8'h00, 4'h0, 4'h0, 4'h0);

        // staggered: channel c runs A=1,0,1,0 starting c cycles late
        for (int t = 0; t < 8; t++) begin
            xa = '0; xs = '0; xk1 = '0; xk2 = '0;
            for (int c = 0; c < 4; c++) begin
                int k;
                k = t - c;
                if (k >= 0 && k < 4) xa[c] = pat_a[k][0];
                if (k >= 0 && k < 3) xs[2*c +: 2] = 2'(k + 1);
                if (k == 2) xk2[c] = 1'b1;
                if (k == 3) xk1[c] = 1'b1;
            end
            step($sformatf("stagger_t%0d", t), 1'b1, 4'hF, xa, xs, xk2, xk1, 4'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
